mac_operand_negator_pipe: RTL and testbench

Parametrised, pipelined operand sign-conditioning stage for the configurable MAC. It takes packed A/B operand buses of `NUM_LANES` lanes and fuses the lanes into groups of 1, 2, 4, … lanes according to the mode. In signed mode it converts each group to magnitude by two's-complement negation, using a carry chain that spans the group. It reports per-lane product sign and most-negative-value flags, and sits between the operand input port and the unsigned partial-product array, using a two-stage valid/ready pipeline.

---
 rtl/mac_operand_negator_pipe_if.sv | 29 ++
 rtl/mac_operand_negator_pipe.sv | 131 +++++++++++++
 tb/tb_mac_operand_negator_pipe.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/mac_operand_negator_pipe_if.sv
// mac_operand_negator_pipe_if: operand-in / magnitude-out handshake bundle for the negator pipe
interface mac_operand_negator_pipe_if #(
  parameter int MAC_MIN_WIDTH = 8,
  parameter int NUM_LANES = 4,
  parameter int MODE_WIDTH = 2
);
  logic in_valid;
  logic in_ready;
  logic [MODE_WIDTH-1:0] mode;
  logic sgn;
  logic [NUM_LANES*MAC_MIN_WIDTH-1:0] A_in;
  logic [NUM_LANES*MAC_MIN_WIDTH-1:0] B_in;
  logic out_valid;
  logic out_ready;
  logic [NUM_LANES*MAC_MIN_WIDTH-1:0] A_out;
  logic [NUM_LANES*MAC_MIN_WIDTH-1:0] B_out;
  logic [NUM_LANES-1:0] C_neg;
  logic [NUM_LANES-1:0] A_minneg;
  logic [NUM_LANES-1:0] B_minneg;
  logic mode_err;
  modport master (
    output in_valid, mode, sgn, A_in, B_in, out_ready,
    input in_ready, out_valid, A_out, B_out, C_neg, A_minneg, B_minneg, mode_err
  );
  modport slave (
    input in_valid, mode, sgn, A_in, B_in, out_ready,
    output in_ready, out_valid, A_out, B_out, C_neg, A_minneg, B_minneg, mode_err
  );
endinterface

// File: rtl/mac_operand_negator_pipe.sv
// mac_operand_negator_pipe: two-stage lane-fusing two's-complement magnitude conditioner
module mac_operand_negator_pipe #(
  parameter int MAC_MIN_WIDTH = 8,
  parameter int NUM_LANES = 4,
  parameter int MODE_WIDTH = 2
) (
  input logic clk,
  input logic rst,
  input logic en,
  mac_operand_negator_pipe_if.slave io
);
  localparam int W = MAC_MIN_WIDTH;
  localparam int L = NUM_LANES;
  localparam int LOG2L = $clog2(NUM_LANES);
  localparam logic [MODE_WIDTH-1:0] MAX_MODE = MODE_WIDTH'(LOG2L);
  localparam logic [W-1:0] MIN_LANE = {1'b1, {(W-1){1'b0}}};
  logic ld1, ld2;
  logic s1_v_q, s2_v_q;
  logic [L*W-1:0] a1_q, b1_q;
  logic [MODE_WIDTH-1:0] mode1_q;
  logic sgn1_q;
  logic [L*W-1:0] a2_q, b2_q, a2_d, b2_d;
  logic [L-1:0] c2_q, am2_q, bm2_q, c_d, am_d, bm_d;
  logic err2_q, err_d;
  logic [MODE_WIDTH-1:0] m;
  logic [L-1:0] lsb;
  logic [L*W-1:0] na, nb;
  logic sa, sb, za, zb;
  int gm, t;
  // Ripple negation: the carry restarts at every group LSB lane so it never crosses a group boundary
  function automatic logic [L*W-1:0] neg_f(input logic [L*W-1:0] v, input logic [L-1:0] first);
    logic c;
    logic [W-1:0] x;
    neg_f = '0;
    c = 1'b0;
    for (int i = 0; i < L; i++) begin
      x = v[i*W +: W];
      c = first[i] | c;
      neg_f[i*W +: W] = ~x + W'(c);
      c = c & ~|x;
    end
  endfunction
  assign ld2 = en & (~s2_v_q | io.out_ready);
  assign ld1 = en & (~s1_v_q | ld2);
  assign io.in_ready = ld1 & ~rst;
  // Stage-1 datapath: group decode, carry chain, select and flag generation
  always_comb begin
    err_d = mode1_q > MAX_MODE;
    m = err_d ? '0 : mode1_q;
    gm = (1 << m) - 1;
    lsb = '0;
    a2_d = '0;
    b2_d = '0;
    c_d = '0;
    am_d = '0;
    bm_d = '0;
    t = 0;
    sa = 1'b0;
    sb = 1'b0;
    za = 1'b0;
    zb = 1'b0;
    for (int i = 0; i < L; i++) lsb[i] = (i & gm) == 0;
    na = neg_f(a1_q, lsb);
    nb = neg_f(b1_q, lsb);
    for (int i = 0; i < L; i++) begin
      t = i | gm;
      sa = a1_q[t*W + W-1];
      sb = b1_q[t*W + W-1];
      a2_d[i*W +: W] = (sgn1_q & sa) ? na[i*W +: W] : a1_q[i*W +: W];
      b2_d[i*W +: W] = (sgn1_q & sb) ? nb[i*W +: W] : b1_q[i*W +: W];
      c_d[i] = sgn1_q & (sa ^ sb);
      za = 1'b1;
      zb = 1'b1;
      for (int j = 0; j < L; j++) begin
        if ((j | gm) == t) begin
          za = za & (a1_q[j*W +: W] == ((j == t) ? MIN_LANE : '0));
          zb = zb & (b1_q[j*W +: W] == ((j == t) ? MIN_LANE : '0));
        end
      end
      am_d[i] = sgn1_q & za;
      bm_d[i] = sgn1_q & zb;
    end
  end
  // Stage 1: capture an accepted beat together with its mode/sign configuration
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v_q <= 1'b0;
      a1_q <= '0;
      b1_q <= '0;
      mode1_q <= '0;
      sgn1_q <= 1'b0;
    end else if (ld1) begin
      s1_v_q <= io.in_valid;
      if (io.in_valid) begin
        a1_q <= io.A_in;
        b1_q <= io.B_in;
        mode1_q <= io.mode;
        sgn1_q <= io.sgn;
      end
    end
  end
  // Stage 2: register conditioned results; held while the consumer stalls
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_v_q <= 1'b0;
      a2_q <= '0;
      b2_q <= '0;
      c2_q <= '0;
      am2_q <= '0;
      bm2_q <= '0;
      err2_q <= 1'b0;
    end else if (ld2) begin
      s2_v_q <= s1_v_q;
      if (s1_v_q) begin
        a2_q <= a2_d;
        b2_q <= b2_d;
        c2_q <= c_d;
        am2_q <= am_d;
        bm2_q <= bm_d;
        err2_q <= err_d;
      end
    end
  end
  assign io.out_valid = s2_v_q;
  assign io.A_out = a2_q;
  assign io.B_out = b2_q;
  assign io.C_neg = c2_q;
  assign io.A_minneg = am2_q;
  assign io.B_minneg = bm2_q;
  assign io.mode_err = err2_q;
endmodule

// File: tb/tb_mac_operand_negator_pipe.sv
// tb_mac_operand_negator_pipe: directed + random scoreboard bench for the negator pipe
module tb_mac_operand_negator_pipe;
  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0] c;
    logic [3:0] am;
    logic [3:0] bm;
    logic e;
  } exp_t;
  logic clk = 1'b0;
  logic rst, en;
  int checks = 0;
  int failures = 0;
  int pops = 0;
  int base;
  exp_t q[$];
  exp_t cur, ye, d[4];
  logic [31:0] ra, rb;
  logic [1:0] rm;
  logic rs;
  always #5 clk = ~clk;
  mac_operand_negator_pipe_if #(.MAC_MIN_WIDTH(8), .NUM_LANES(4), .MODE_WIDTH(2)) ifc ();
  mac_operand_negator_pipe #(.MAC_MIN_WIDTH(8), .NUM_LANES(4), .MODE_WIDTH(2)) dut (
    .clk(clk), .rst(rst), .en(en), .io(ifc)
  );
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask
  // Reference: whole-group integer negation, independent of any per-lane carry chain
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic [1:0] md, input logic s);
    exp_t r;
    int g, gw;
    logic [63:0] mask, lim, va, vb;
    logic nga, ngb, ma, mb;
    r = '0;
    r.e = md > 2'd2;
    g = r.e ? 1 : (1 << md);
    gw = g * 8;
    mask = (64'd1 << gw) - 64'd1;
    lim = 64'd1 << (gw - 1);
    for (int k = 0; k < 4; k += g) begin
      va = ({32'd0, a} >> (k * 8)) & mask;
      vb = ({32'd0, b} >> (k * 8)) & mask;
      nga = s && ((va & lim) != 0);
      ngb = s && ((vb & lim) != 0);
      ma = s && (va == lim);
      mb = s && (vb == lim);
      if (nga) va = (~va + 64'd1) & mask;
      if (ngb) vb = (~vb + 64'd1) & mask;
      for (int j = k; j < k + g; j++) begin
        r.a[j*8 +: 8] = va[(j-k)*8 +: 8];
        r.b[j*8 +: 8] = vb[(j-k)*8 +: 8];
        r.c[j] = nga ^ ngb;
        r.am[j] = ma;
        r.bm[j] = mb;
      end
    end
    return r;
  endfunction
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [1:0] md, input logic s, input exp_t e);
    int n;
    n = 0;
    ifc.A_in = a;
    ifc.B_in = b;
    ifc.mode = md;
    ifc.sgn = s;
    ifc.in_valid = 1'b1;
    @(negedge clk);
    while (ifc.in_ready !== 1'b1 && n < 20) begin
      n++;
      @(negedge clk);
    end
    checks++;
    assert (ifc.in_ready === 1'b1) else begin
      failures++;
      $error("FAIL accept_timeout observed=in_ready=%b expected=1", ifc.in_ready);
    end
    if (ifc.in_ready === 1'b1) q.push_back(e);
    @(posedge clk);
    #1 ifc.in_valid = 1'b0;
  endtask
  // Scoreboard consumer: every consumed beat must match the oldest expected entry
  always @(negedge clk) begin
    if (rst === 1'b0 && en === 1'b1 && ifc.out_valid === 1'b1 && ifc.out_ready === 1'b1) begin
      checks++;
      assert (q.size() > 0) else begin
        failures++;
        $error("FAIL unexpected_beat observed=out_valid=1 expected=no beat pending");
      end
      if (q.size() > 0) begin
        cur = q.pop_front();
        check("A_out", ifc.A_out, cur.a);
        check("B_out", ifc.B_out, cur.b);
        check("C_neg", 32'(ifc.C_neg), 32'(cur.c));
        check("A_minneg", 32'(ifc.A_minneg), 32'(cur.am));
        check("B_minneg", 32'(ifc.B_minneg), 32'(cur.bm));
        check("mode_err", 32'(ifc.mode_err), 32'(cur.e));
      end
      pops++;
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    rst = 1'b1;
    en = 1'b1;
    ifc.in_valid = 1'b0;
    ifc.out_ready = 1'b1;
    ifc.A_in = '0;
    ifc.B_in = '0;
    ifc.mode = '0;
    ifc.sgn = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 32'(ifc.in_ready), 32'd0);
    check("rst_out_valid", 32'(ifc.out_valid), 32'd0);
    check("rst_A_out", ifc.A_out, 32'd0);
    check("rst_B_out", ifc.B_out, 32'd0);
    check("rst_flags", {16'd0, ifc.C_neg, ifc.A_minneg, ifc.B_minneg, 3'd0, ifc.mode_err}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    send(32'h0005_80FF, 32'h0000_0101, 2'd0, 1'b1, '{32'h0005_8001, 32'h0000_0101, 4'b0011, 4'b0010, 4'b0000, 1'b0});
    @(negedge clk);
    check("lat_stage1", 32'(ifc.out_valid), 32'd0);
    @(negedge clk);
    check("lat_stage2", 32'(ifc.out_valid), 32'd1);
    @(posedge clk);
    #1;
    send(32'h0100_FF00, 32'h8000_0001, 2'd1, 1'b1, '{32'h0100_0100, 32'h8000_0001, 4'b1111, 4'b0000, 4'b1100, 1'b0});
    send(32'hFFFF_FFFF, 32'h0000_0003, 2'd2, 1'b1, '{32'h0000_0001, 32'h0000_0003, 4'b1111, 4'b0000, 4'b0000, 1'b0});
    send(32'hFFFF_FFFF, 32'h0000_0003, 2'd2, 1'b0, '{32'hFFFF_FFFF, 32'h0000_0003, 4'b0000, 4'b0000, 4'b0000, 1'b0});
    send(32'hFFFF_FFFF, 32'h0000_0000, 2'd3, 1'b1, '{32'h0101_0101, 32'h0000_0000, 4'b1111, 4'b0000, 4'b0000, 1'b1});
    send(32'h1234_5678, 32'h9ABC_DEF0, 2'd0, 1'b0, '{32'h1234_5678, 32'h9ABC_DEF0, 4'b0000, 4'b0000, 4'b0000, 1'b0});
    send(32'h8000_0000, 32'h0080_0000, 2'd2, 1'b1, '{32'h8000_0000, 32'h0080_0000, 4'b1111, 4'b1111, 4'b0000, 1'b0});
    for (int i = 0; i < 10; i++) begin
      ra = $urandom;
      rb = $urandom;
      rm = 2'($urandom_range(0, 3));
      rs = 1'($urandom_range(0, 1));
      send(ra, rb, rm, rs, model(ra, rb, rm, rs));
    end
    repeat (3) @(negedge clk);
    check("drain_random", q.size(), 32'd0);
    @(posedge clk);
    #1 ifc.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) d[i] = model(32'hA0B0_C0D0 + i, 32'h0F0F_8000 - i, 2'(i), 1'b1);
    send(32'hA0B0_C0D0, 32'h0F0F_8000, 2'd0, 1'b1, d[0]);
    send(32'hA0B0_C0D1, 32'h0F0F_7FFF, 2'd1, 1'b1, d[1]);
    ifc.A_in = 32'hA0B0_C0D2;
    ifc.B_in = 32'h0F0F_7FFE;
    ifc.mode = 2'd2;
    ifc.in_valid = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("bp_in_ready", 32'(ifc.in_ready), 32'd0);
      check("bp_out_valid", 32'(ifc.out_valid), 32'd1);
    end
    @(posedge clk);
    #1 ifc.out_ready = 1'b1;
    base = pops;
    send(32'hA0B0_C0D2, 32'h0F0F_7FFE, 2'd2, 1'b1, d[2]);
    send(32'hA0B0_C0D3, 32'h0F0F_7FFD, 2'd3, 1'b1, d[3]);
    repeat (2) @(negedge clk);
    #1;
    check("bp_stream_beats", pops - base, 32'd4);
    check("bp_queue_empty", q.size(), 32'd0);
    @(posedge clk);
    #1 ifc.out_ready = 1'b0;
    send(32'h1111_1111, 32'h2222_2222, 2'd0, 1'b1, model(32'h1111_1111, 32'h2222_2222, 2'd0, 1'b1));
    send(32'h3333_3333, 32'h4444_4444, 2'd0, 1'b1, model(32'h3333_3333, 32'h4444_4444, 2'd0, 1'b1));
    rst = 1'b1;
    q.delete();
    @(negedge clk);
    check("rst_mid_in_ready", 32'(ifc.in_ready), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    ifc.out_ready = 1'b1;
    @(negedge clk);
    check("rst_mid_out_valid", 32'(ifc.out_valid), 32'd0);
    check("rst_mid_A_out", ifc.A_out, 32'd0);
    check("rst_mid_in_ready_back", 32'(ifc.in_ready), 32'd1);
    repeat (3) begin
      @(negedge clk);
      check("rst_no_emit", 32'(ifc.out_valid), 32'd0);
    end
    @(posedge clk);
    #1 ifc.out_ready = 1'b0;
    ye = model(32'hFE80_7F01, 32'h8001_00FF, 2'd1, 1'b1);
    send(32'hFE80_7F01, 32'h8001_00FF, 2'd1, 1'b1, ye);
    @(posedge clk);
    #1 en = 1'b0;
    ifc.out_ready = 1'b1;
    ifc.A_in = 32'h5555_5555;
    ifc.in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("en0_in_ready", 32'(ifc.in_ready), 32'd0);
      check("en0_out_valid", 32'(ifc.out_valid), 32'd1);
      check("en0_A_frozen", ifc.A_out, ye.a);
      check("en0_B_frozen", ifc.B_out, ye.b);
    end
    @(posedge clk);
    #1 en = 1'b1;
    ifc.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("en_final_queue", q.size(), 32'd0);
    check("en_no_extra_beat", 32'(ifc.out_valid), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
